// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game pattern player.
package memgame_pkg;

  localparam int unsigned MAX_PATTERN_LEN = 32;
  localparam int unsigned LEN_W           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } player_state_t;

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loaded on every state entry, stops at 1 and never wraps.
module phase_timer
  import memgame_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  output logic             expired
);

  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q > LEN_W'(1)) begin
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

  // The last cycle of a phase is the one in which the count reads 1.
  assign expired = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/pattern_player.sv
// Plays back a captured game pattern on an LED, oldest bit first, with
// per-bit on time and inter-bit blank time.
module pattern_player
  import memgame_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned MAX_LEN    = MAX_PATTERN_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               led_on,
  output logic               led_bit,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] OnLoad  = LEN_W'(ON_CYCLES);
  localparam logic [LEN_W-1:0] GapLoad = LEN_W'(GAP_CYCLES);

  player_state_t      state_q, state_d;
  logic [MAX_LEN-1:0] captured_q, captured_d;
  logic [LEN_W-1:0]   bitsLeft_q, bitsLeft_d;
  logic               ledOn_q, ledBit_q, busy_q, done_q;

  logic               timerLoad;
  logic [LEN_W-1:0]   timerLoadVal;
  logic               timerExpired;
  logic [LEN_W-1:0]   clampLen;
  logic [MAX_LEN-1:0] shifted;

  phase_timer uPhaseTimer (
    .clk      (clk),
    .rst      (rst),
    .load     (timerLoad),
    .load_val (timerLoadVal),
    .expired  (timerExpired)
  );

  assign clampLen = (length > MaxLenW) ? MaxLenW : length;

  // Next-state logic; every state transition also reloads the phase timer.
  always_comb begin
    state_d      = state_q;
    captured_d   = captured_q;
    bitsLeft_d   = bitsLeft_q;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          captured_d = pattern;
          bitsLeft_d = clampLen;
          timerLoad  = 1'b1;
          if (clampLen != '0) begin
            state_d      = SHOW;
            timerLoadVal = OnLoad;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHOW: begin
        if (abort) begin
          state_d   = IDLE;
          timerLoad = 1'b1;
        end else if (timerExpired) begin
          bitsLeft_d = bitsLeft_q - LEN_W'(1);
          timerLoad  = 1'b1;
          if (bitsLeft_q == LEN_W'(1)) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d      = SHOW;
            timerLoadVal = OnLoad;
          end else begin
            state_d      = GAP;
            timerLoadVal = GapLoad;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          timerLoad = 1'b1;
        end else if (timerExpired) begin
          state_d      = SHOW;
          timerLoad    = 1'b1;
          timerLoadVal = OnLoad;
        end
      end
      DONE: begin
        state_d   = IDLE;
        timerLoad = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifting instead of a variable bit-select keeps the index width independent of MAX_LEN.
  assign shifted = captured_d >> (bitsLeft_d - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      captured_q <= '0;
      bitsLeft_q <= '0;
      ledOn_q    <= 1'b0;
      ledBit_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      bitsLeft_q <= bitsLeft_d;
      ledOn_q    <= (state_d == SHOW);
      ledBit_q   <= (state_d == SHOW) && shifted[0];
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign led_on  = ledOn_q;
  assign led_bit = ledBit_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Scoreboard bench for pattern_player: stimulus pushes expected LED/done events,
// a negedge monitor pops and compares them as the player emits them.
module tb_pattern_player;

  localparam int ON  = 2;
  localparam int GAP = 1;

  typedef struct {
    bit   isDone;
    int   cyc;
    logic val;
  } expItem_t;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [31:0] pattern;
  logic [15:0] length;
  logic        ledOn, ledBit, busy, done;

  logic        start2;
  logic [31:0] pattern2;
  logic [15:0] length2;
  logic        ledOn2, ledBit2, busy2, done2;

  int          cyc;
  int          vectors;
  int          miscompares;
  expItem_t    expQ[$];

  pattern_player #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_LEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .length  (length),
    .led_on  (ledOn),
    .led_bit (ledBit),
    .busy    (busy),
    .done    (done)
  );

  pattern_player #(.ON_CYCLES(1), .GAP_CYCLES(0), .MAX_LEN(32)) dutGap0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .abort   (1'b0),
    .pattern (pattern2),
    .length  (length2),
    .led_on  (ledOn2),
    .led_bit (ledBit2),
    .busy    (busy2),
    .done    (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events for a playback started in cycle t; events after abortAt are dropped.
  task automatic pushPlay(input int t, input logic [31:0] pat, input int len, input int abortAt);
    int       L;
    int       cy;
    int       doneC;
    expItem_t e;
    L = (len > 32) ? 32 : len;
    for (int i = 0; i < L; i++) begin
      for (int c = 0; c < ON; c++) begin
        cy = t + 1 + i * (ON + GAP) + c;
        if (cy <= abortAt) begin
          e.isDone = 1'b0; e.cyc = cy; e.val = pat[L-1-i];
          expQ.push_back(e);
        end
      end
    end
    doneC = (L == 0) ? t + 1 : t + 1 + L * ON + (L - 1) * GAP;
    if (doneC <= abortAt) begin
      e.isDone = 1'b1; e.cyc = doneC; e.val = 1'b1;
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pat, input int len, input int abortRel, output int t);
    @(posedge clk); #1;
    start   = 1'b1;
    pattern = pat;
    length  = 16'(len);
    t       = cyc;
    pushPlay(t, pat, len, t + abortRel);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((busy || expQ.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_reaches_idle"}, 32'(n < 300), 32'd1);
    if (n >= 300) expQ.delete();
  endtask

  // Monitor: every LED or done cycle must match the head of the scoreboard.
  expItem_t mItem;
  always @(negedge clk) begin
    if (ledOn || done) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_output: cycle %0d led_on=%b led_bit=%b done=%b, expected no output",
                 cyc, ledOn, ledBit, done);
      end else begin
        mItem = expQ.pop_front();
        if (mItem.isDone !== (done && !ledOn) || mItem.cyc != cyc ||
            (!mItem.isDone && mItem.val !== ledBit)) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got cycle %0d led_on=%b led_bit=%b done=%b, expected cycle %0d %s bit=%b",
                   cyc, ledOn, ledBit, done, mItem.cyc, mItem.isDone ? "done" : "led", mItem.val);
        end
      end
    end else begin
      checkOutput("led_bit_zero_when_off", 32'(ledBit), 32'd0);
    end
  end

  initial begin
    int t;
    int cnt, firstOn, lastOn, doneC, bad;

    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; length = '0;
    start2 = 1'b0; pattern2 = '0; length2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_led_on", 32'(ledOn), 32'd0);
    checkOutput("reset_led_bit", 32'(ledBit), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    $display("[TB] basic 3-bit pattern 101");
    applyStimulus(32'b101, 3, 1000, t);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitIdle("basic101");

    $display("[TB] zero length");
    applyStimulus(32'hFFFF_FFFF, 0, 1000, t);
    waitIdle("len0");

    $display("[TB] 5-bit mixed pattern");
    applyStimulus(32'b10110, 5, 1000, t);
    waitIdle("len5");

    $display("[TB] start and abort together in IDLE");
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; pattern = 32'h1; length = 16'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] abort during second bit");
    applyStimulus(32'b101, 3, 4, t);
    waitCycle(t + 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_led_on", 32'(ledOn), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    waitIdle("abort");
    applyStimulus(32'b101, 3, 1000, t);
    waitIdle("replay_after_abort");

    $display("[TB] start and pattern changes mid-play");
    applyStimulus(32'b101, 3, 1000, t);
    waitCycle(t + 3);
    start = 1'b1; pattern = 32'hFFFF_FFFF; length = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    waitCycle(t + 6);
    pattern = 32'h0; length = 16'd1;
    waitIdle("disturbed");

    $display("[TB] reset mid-SHOW");
    applyStimulus(32'b101, 3, 2, t);
    waitCycle(t + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_led_on", 32'(ledOn), 32'd0);
    checkOutput("rst_led_bit", 32'(ledBit), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    applyStimulus(32'b011, 3, 1000, t);
    waitIdle("after_rst");

    $display("[TB] clamped length 40, ON=1 GAP=0");
    @(posedge clk); #1;
    start2 = 1'b1; pattern2 = 32'hFFFF_FFFF; length2 = 16'd40;
    t = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    cnt = 0; firstOn = -1; lastOn = -1; doneC = -1; bad = 0;
    for (int k = 0; k < 45; k++) begin
      if (ledOn2) begin
        cnt++;
        if (firstOn < 0) firstOn = cyc;
        lastOn = cyc;
        if (!ledBit2) bad++;
      end
      if (done2) doneC = cyc;
      @(posedge clk); #1;
    end
    checkOutput("clamp_on_count", 32'(cnt), 32'd32);
    checkOutput("clamp_first_on", 32'(firstOn), 32'(t + 1));
    checkOutput("clamp_contiguous", 32'(lastOn - firstOn + 1), 32'd32);
    checkOutput("clamp_bits_one", 32'(bad), 32'd0);
    checkOutput("clamp_done_cycle", 32'(doneC), 32'(t + 33));

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
